buffer_fifo: RTL
================

BUFFER_FIFO -- requirements
Module: buffer_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of storage entries; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_LEVEL, default 14, meaning count at or above which afull_out asserts; range 1..DEPTH.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_in  input  1  synchronous clear of contents.
REQ-007 SHALL have port write_en_in  input  1  write request.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-009 SHALL have port read_en_in  input  1  read request.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-011 SHALL have port full_out  output  1  count == DEPTH.
REQ-012 SHALL have port empty_out  output  1  count == 0.
REQ-013 SHALL have port afull_out  output  1  count >= AFULL_LEVEL.
REQ-014 SHALL have port count_out  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow_out  output  1  one-cycle pulse, write rejected.
REQ-016 SHALL have port underflow_out  output  1  one-cycle pulse, read rejected.

Function
REQ-017 SHALL store words in arrival order; read pointer, write pointer clog2(DEPTH) bits, wrap modulo DEPTH with no extra logic.
REQ-018 SHALL accept a write when write_en_in=1 and (full_out=0 or an accepted read occurs in the same cycle).
REQ-019 SHALL accept a read when read_en_in=1 and empty_out=0; data_out updates on the same clock edge with the oldest word (1-cycle latency, not first-word fall-through).
REQ-020 SHALL hold data_out unchanged in any cycle without an accepted read, including flush.
REQ-021 SHALL, on simultaneous accepted read and write, keep count_out unchanged and advance both pointers.
REQ-022 SHALL, when empty and read+write asserted together, accept the write only and pulse underflow_out (no bypass).
REQ-023 SHALL, when full and write without read, ignore the write, leave storage untouched, and pulse overflow_out for one cycle.
REQ-024 SHALL, when empty and read without write, leave data_out unchanged and pulse underflow_out for one cycle.
REQ-025 SHALL give flush_in priority over same-cycle read/write: pointers and count to 0, no read/write accepted, no overflow/underflow pulse.
REQ-026 SHALL derive full_out, empty_out, afull_out from registered count, valid the cycle after the causing edge.

Reset
REQ-027 SHALL, on rst_n low, immediately set pointers and count_out to 0, data_out to 0, empty_out to 1, full_out/afull_out/overflow_out/underflow_out to 0.
REQ-028 SHALL discard any in-flight operation when reset asserts mid-operation; storage array contents need not be reset.
REQ-029 SHALL accept the first write on the first rising edge with rst_n high.

Structure
REQ-030 SHALL keep shared constant helper (clog2 function, default DEPTH/DATA_WIDTH) in package buffer_pkg; no typedefs required.
REQ-031 SHALL place storage in sub-module buffer_mem: simple dual-port array, one write port, registered read port with read-enable.
REQ-032 SHALL keep pointer, count and flag control in buffer_fifo top.

Verification
REQ-033 Reset, write 0x11,0x22,0x33, read 3 -> data_out 0x11,0x22,0x33 on successive edges, empty_out=1 after third read.
REQ-034 Write 16 words (DEPTH=16), then 17th write -> full_out=1, overflow_out one pulse, count_out=16, 17th word never read.
REQ-035 Full FIFO, read+write 0xAA same cycle -> count_out stays 16, 0xAA emerges as 16th subsequent read.
REQ-036 Empty, read+write 0x5C -> underflow_out pulse, count_out=1, next read gives 0x5C.
REQ-037 Count 13->14 -> afull_out rises with count_out=14; 20 write/read cycles across wrap -> order preserved.
REQ-038 Count 5, flush_in with write -> count_out=0, empty_out=1, data_out unchanged; rst_n low mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/buffer_pkg.sv
// buffer_pkg: shared constants and width helper for the buffer FIFO
package buffer_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/buffer_mem.sv
// buffer_mem: simple dual-port storage, one write port, registered read port
module buffer_mem
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // storage array has no reset; only written words are ever read
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // read register holds its value unless a read is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/buffer_fifo.sv
// buffer_fifo: synchronous FIFO with count, almost-full and over/underflow pulses
module buffer_fifo
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_LEVEL = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_in,
  input  logic                    write_en_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read_en_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full_out,
  output logic                    empty_out,
  output logic                    afull_out,
  output logic [clog2(DEPTH):0]   count_out,
  output logic                    overflow_out,
  output logic                    underflow_out
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic rd_ok, wr_ok;
  assign empty_out = count_out == '0;
  assign full_out = count_out == CW'(DEPTH);
  assign afull_out = count_out >= CW'(AFULL_LEVEL);
  // a read frees a slot, so a full FIFO still takes a write alongside a read
  assign rd_ok = read_en_in & ~empty_out & ~flush_in;
  assign wr_ok = write_en_in & (~full_out | rd_ok) & ~flush_in;
  buffer_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr_ok),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re(rd_ok),
    .raddr(rd_ptr),
    .rdata(data_out)
  );
  // pointers, occupancy and one-cycle error pulses; flush overrides everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_out <= '0;
      overflow_out <= 1'b0;
      underflow_out <= 1'b0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_out <= '0;
      overflow_out <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
      count_out <= count_out + CW'(wr_ok) - CW'(rd_ok);
      overflow_out <= write_en_in & ~wr_ok;
      underflow_out <= read_en_in & ~rd_ok;
    end
endmodule
